// File: rtl/shift_cmd_gen_pkg.sv
// Shared definitions for the push-button shift command generator:
// arbitration FSM encodings, default timing constants and parameter range check.
package shift_cmd_gen_pkg;

  typedef enum logic [1:0] {
    SCG_IDLE   = 2'd0,
    SCG_HOLD_L = 2'd1,
    SCG_HOLD_R = 2'd2,
    SCG_LOCK   = 2'd3
  } scg_state_e;

  localparam int SCG_DEBOUNCE_CYCLES = 4;
  localparam int SCG_REPEAT_DELAY    = 10;
  localparam int SCG_REPEAT_PERIOD   = 3;
  localparam int SCG_CNT_W           = 8;

  // A timing value must be nonzero and representable in the counter width.
  function automatic bit scg_param_ok(input int value, input int cnt_w);
    return (value >= 1) && (value <= (1 << cnt_w) - 1);
  endfunction

endpackage

// File: rtl/shift_cmd_gen_if.sv
// Board-side button inputs and shifter-side command/level outputs of shift_cmd_gen.
// master drives the buttons and observes commands; slave is the generator itself.
interface shift_cmd_gen_if;
  logic btn_left_raw;
  logic btn_right_raw;
  logic enable_repeat;
  logic shift_left;
  logic shift_right;
  logic left_held;
  logic right_held;

  modport master (
    output btn_left_raw, btn_right_raw, enable_repeat,
    input  shift_left, shift_right, left_held, right_held
  );

  modport slave (
    input  btn_left_raw, btn_right_raw, enable_repeat,
    output shift_left, shift_right, left_held, right_held
  );
endinterface

// File: rtl/shift_cmd_gen_btn_debounce.sv
// One button: 2-flop synchroniser, mismatch counter and debounced level register.
// A raw change sampled at edge 0 shows on level_o from cycle DEBOUNCE_CYCLES+2.
module shift_cmd_gen_btn_debounce
  import shift_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SCG_DEBOUNCE_CYCLES,
  parameter int CNT_W           = SCG_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;

  // The flip is committed one edge after the count reaches the limit, so the
  // counter never has to hold a value above DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (cnt_q >= CNT_LIMIT) begin
      level_d = ~level_q;
    end else if (sync2_q != level_q) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/shift_cmd_gen.sv
// Debounces two buttons and arbitrates them into one-cycle shift_left/shift_right pulses,
// with optional auto-repeat; first pulse lands in cycle DEBOUNCE_CYCLES+3 after the press.
module shift_cmd_gen
  import shift_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SCG_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = SCG_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = SCG_REPEAT_PERIOD,
  parameter int CNT_W           = SCG_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  shift_cmd_gen_if.slave cmd_if
);

  localparam logic [CNT_W-1:0] REP_DELAY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_PERIOD = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] REP_ONE    = CNT_W'(1);

  logic             lvl_l;
  logic             lvl_r;
  logic             prev_l_q;
  logic             prev_r_q;
  logic             rise_l;
  logic             rise_r;
  logic             en;
  scg_state_e       state_q;
  scg_state_e       state_d;
  logic [CNT_W-1:0] rep_q;
  logic [CNT_W-1:0] rep_d;
  logic [CNT_W-1:0] rep_next;
  logic [CNT_W-1:0] rep_thr;
  logic             rep_due;
  logic             rep_first_q;
  logic             rep_first_d;
  logic             shl_q;
  logic             shl_d;
  logic             shr_q;
  logic             shr_d;

  always_ff @(posedge clk) begin : p_param_check
    assert (scg_param_ok(DEBOUNCE_CYCLES, CNT_W) && scg_param_ok(REPEAT_DELAY, CNT_W) &&
            scg_param_ok(REPEAT_PERIOD, CNT_W))
      else $error("shift_cmd_gen: timing parameter outside 1..2**CNT_W-1");
  end

  shift_cmd_gen_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (cmd_if.btn_left_raw),
    .level_o(lvl_l)
  );

  shift_cmd_gen_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (cmd_if.btn_right_raw),
    .level_o(lvl_r)
  );

  assign en     = cmd_if.enable_repeat;
  assign rise_l = lvl_l & ~prev_l_q;
  assign rise_r = lvl_r & ~prev_r_q;

  // rep_q counts cycles since the last pulse; it sits at 0 while repeat is
  // disabled, so re-enabling always waits the full initial delay again.
  assign rep_thr  = rep_first_q ? REP_DELAY : REP_PERIOD;
  assign rep_due  = en & (rep_q >= rep_thr);
  assign rep_next = !en ? '0 : ((rep_q == '1) ? rep_q : rep_q + REP_ONE);

  always_comb begin
    state_d     = state_q;
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
    shl_d       = 1'b0;
    shr_d       = 1'b0;
    case (state_q)
      SCG_IDLE: begin
        if (rise_l && rise_r) begin
          state_d = SCG_LOCK;
        end else if (rise_l) begin
          shl_d       = 1'b1;
          state_d     = SCG_HOLD_L;
          rep_d       = en ? REP_ONE : '0;
          rep_first_d = 1'b1;
        end else if (rise_r) begin
          shr_d       = 1'b1;
          state_d     = SCG_HOLD_R;
          rep_d       = en ? REP_ONE : '0;
          rep_first_d = 1'b1;
        end
      end
      // A rising opposite button wins over a same-cycle release, so IDLE is
      // only ever entered with both levels low.
      SCG_HOLD_L: begin
        if (rise_r) begin
          state_d = SCG_LOCK;
        end else if (!lvl_l) begin
          state_d = SCG_IDLE;
        end else if (rep_due) begin
          shl_d       = 1'b1;
          rep_d       = REP_ONE;
          rep_first_d = 1'b0;
        end else begin
          rep_d       = rep_next;
          rep_first_d = rep_first_q | ~en;
        end
      end
      SCG_HOLD_R: begin
        if (rise_l) begin
          state_d = SCG_LOCK;
        end else if (!lvl_r) begin
          state_d = SCG_IDLE;
        end else if (rep_due) begin
          shr_d       = 1'b1;
          rep_d       = REP_ONE;
          rep_first_d = 1'b0;
        end else begin
          rep_d       = rep_next;
          rep_first_d = rep_first_q | ~en;
        end
      end
      SCG_LOCK: begin
        if (!lvl_l && !lvl_r) begin
          state_d = SCG_IDLE;
        end
      end
      default: state_d = SCG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCG_IDLE;
      rep_q       <= '0;
      rep_first_q <= 1'b0;
      prev_l_q    <= 1'b0;
      prev_r_q    <= 1'b0;
      shl_q       <= 1'b0;
      shr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
      prev_l_q    <= lvl_l;
      prev_r_q    <= lvl_r;
      shl_q       <= shl_d;
      shr_q       <= shr_d;
    end
  end

  assign cmd_if.shift_left  = shl_q;
  assign cmd_if.shift_right = shr_q;
  assign cmd_if.left_held   = lvl_l;
  assign cmd_if.right_held  = lvl_r;

endmodule
